// File: rtl/pic_ctrl.sv
// pic_ctrl: priority interrupt controller; define PIC_OVERRUN_EN to add sticky per-source overrun flags (ovr).
module pic_ctrl #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_wdata,
  input  logic             int_ack,
  output logic [7:0]       pic_out,
  output logic             ack_err
`ifdef PIC_OVERRUN_EN
  ,
  output logic [N_SRC-1:0] ovr
`endif
);
  logic [N_SRC-1:0]      en, en_nxt, pend, pend_nxt, irq_q, edg, cfg_hit, ack_hit;
  logic [N_SRC-1:0][2:0] pri, pri_nxt;
  logic [N_SRC-1:0][3:0] vec, vec_nxt;
  logic [IDX_W-1:0]      win_idx, best_idx;
  logic [2:0]            best_pri;
  logic [3:0]            best_vec;
  logic                  found, ack_ok;
  assign edg    = irq & ~irq_q;
  assign ack_ok = int_ack & pic_out[7];
  // a disabling write beats a new edge, which in turn beats the ack retiring it
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      cfg_hit[i]  = cfg_we && cfg_idx == IDX_W'(i);
      ack_hit[i]  = ack_ok && win_idx == IDX_W'(i);
      en_nxt[i]   = cfg_hit[i] ? cfg_wdata[7] : en[i];
      pri_nxt[i]  = cfg_hit[i] ? cfg_wdata[6:4] : pri[i];
      vec_nxt[i]  = cfg_hit[i] ? cfg_wdata[3:0] : vec[i];
      pend_nxt[i] = (cfg_hit[i] && !cfg_wdata[7]) ? 1'b0 :
                    (en[i] && edg[i]) ? 1'b1 :
                    ack_hit[i] ? 1'b0 : pend[i];
    end
  end
  // strict compare while scanning upward keeps ties on the lowest index
  always_comb begin
    found    = 1'b0;
    best_pri = '0;
    best_vec = '0;
    best_idx = '0;
    for (int i = 0; i < N_SRC; i++)
      if (pend_nxt[i] && (!found || pri_nxt[i] > best_pri)) begin
        found    = 1'b1;
        best_pri = pri_nxt[i];
        best_vec = vec_nxt[i];
        best_idx = IDX_W'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en      <= '0;
      pri     <= '0;
      vec     <= '0;
      pend    <= '0;
      irq_q   <= '0;
      win_idx <= '0;
      pic_out <= 8'h00;
      ack_err <= 1'b0;
    end else begin
      en      <= en_nxt;
      pri     <= pri_nxt;
      vec     <= vec_nxt;
      pend    <= pend_nxt;
      irq_q   <= irq;
      win_idx <= best_idx;
      pic_out <= found ? {1'b1, best_pri, best_vec} : 8'h00;
      ack_err <= int_ack & ~pic_out[7];
    end
  end
`ifdef PIC_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ovr <= '0;
    else
      for (int i = 0; i < N_SRC; i++)
        if (cfg_hit[i]) ovr[i] <= 1'b0;
        else if (edg[i] && pend[i] && !ack_hit[i]) ovr[i] <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_pic_ctrl.sv
// tb_pic_ctrl: directed self-checking bench for pic_ctrl (ovr checks only when PIC_OVERRUN_EN is defined).
module tb_pic_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, cfg_we, int_ack, ack_err;
  logic [7:0] irq, cfg_wdata, pic_out;
  logic [2:0] cfg_idx;
  int         checks = 0, failures = 0;
`ifdef PIC_OVERRUN_EN
  logic [7:0] ovr;
`endif
  pic_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .int_ack(int_ack), .pic_out(pic_out), .ack_err(ack_err)
`ifdef PIC_OVERRUN_EN
    , .ovr(ovr)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; irq = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0; int_ack = 1'b0;
    tick(); tick();
    chk("rst_out", pic_out, 8'h00);
    chk("rst_err", {7'b0, ack_err}, 8'h00);
    rst_n = 1'b1;
    cfg(2, 8'hB5);
    irq = 8'h04; tick();
    chk("t1_show", pic_out, 8'hB5);
    irq = 8'h00; ack();
    chk("t1_ack", pic_out, 8'h00);
    chk("t1_noerr", {7'b0, ack_err}, 8'h00);
    cfg(1, 8'h92); cfg(4, 8'hE9);
    irq = 8'h12; tick();
    chk("t2_hi", pic_out, 8'hE9);
    irq = 8'h00; ack();
    chk("t2_lo", pic_out, 8'h92);
    ack();
    chk("t2_none", pic_out, 8'h00);
    cfg(0, 8'hC1); cfg(3, 8'hC7);
    irq = 8'h09; tick();
    chk("t3_tie", pic_out, 8'hC1);
    irq = 8'h00; ack();
    chk("t3_next", pic_out, 8'hC7);
    ack();
    chk("t3_none", pic_out, 8'h00);
    cfg(5, 8'h23);
    irq = 8'h20; tick();
    chk("t4_dis", pic_out, 8'h00);
    irq = 8'h00; tick();
    cfg(5, 8'hA3);
    tick();
    chk("t4_noedge", pic_out, 8'h00);
    irq = 8'h20; tick();
    chk("t4_edge", pic_out, 8'hA3);
    irq = 8'h00; ack();
    chk("t4_ack", pic_out, 8'h00);
    irq = 8'h02; tick();
    chk("t5_lo", pic_out, 8'h92);
    irq = 8'h00; tick();
    chk("t5_hold", pic_out, 8'h92);
    irq = 8'h10; tick();
    chk("t5_preempt", pic_out, 8'hE9);
    irq = 8'h00; ack();
    chk("t5_back", pic_out, 8'h92);
    ack();
    chk("t5_none", pic_out, 8'h00);
    ack();
    chk("t5_err", {7'b0, ack_err}, 8'h01);
    chk("t5_err_out", pic_out, 8'h00);
    tick();
    chk("t5_err_once", {7'b0, ack_err}, 8'h00);
    irq = 8'h04; tick();
    chk("reedge_show", pic_out, 8'hB5);
    irq = 8'h00; tick();
    irq = 8'h04; ack();
    chk("reedge_keep", pic_out, 8'hB5);
`ifdef PIC_OVERRUN_EN
    chk("reedge_noovr", ovr, 8'h00);
`endif
    irq = 8'h00; ack();
    chk("reedge_gone", pic_out, 8'h00);
    irq = 8'h04; tick();
    irq = 8'h00;
    cfg(2, 8'h35);
    chk("dis_clear", pic_out, 8'h00);
    cfg(2, 8'hB5);
    irq = 8'h03; tick();
    chk("rep_before", pic_out, 8'hC1);
    irq = 8'h00;
    cfg(1, 8'hF2);
    chk("rep_after", pic_out, 8'hF2);
    ack();
    chk("rep_ack1", pic_out, 8'hC1);
    ack();
    chk("rep_ack2", pic_out, 8'h00);
    irq = 8'h04; tick();
    irq = 8'h00; tick();
    irq = 8'h04; tick();
`ifdef PIC_OVERRUN_EN
    chk("ovr_set", ovr, 8'h04);
    irq = 8'h00;
    cfg(2, 8'hB5);
    chk("ovr_clr", ovr, 8'h00);
    chk("ovr_pend", pic_out, 8'hB5);
    irq = 8'h04; tick();
    chk("ovr_set2", ovr, 8'h04);
`endif
    chk("mid_show", pic_out, 8'hB5);
    rst_n = 1'b0; irq = 8'h00; tick();
    chk("mid_rst", pic_out, 8'h00);
`ifdef PIC_OVERRUN_EN
    chk("mid_rst_ovr", ovr, 8'h00);
`endif
    rst_n = 1'b1;
    irq = 8'h04; tick();
    chk("post_rst_cfg", pic_out, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
